// File: rtl/param_sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
// The read-mode encodings are common to every FIFO variant.
package param_sync_fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for param_sync_fifo.
// Writes are synchronous and reads are asynchronous; there is no reset, so contents survive a FIFO reset.
module sync_fifo_ram #(
    parameter int pAddrWidth = 5,
    parameter int pWordWidth = 16
) (
    input  logic                  iClk,
    input  logic                  iWEn,
    input  logic [pAddrWidth-1:0] ivWrAddr,
    input  logic [pWordWidth-1:0] ivWrData,
    input  logic [pAddrWidth-1:0] ivRdAddr,
    output logic [pWordWidth-1:0] ovRdData
);

    logic [pWordWidth-1:0] mem [2**pAddrWidth];

    // Write port
    always_ff @(posedge iClk) begin
        if (iWEn) begin
            mem[ivWrAddr] <= ivWrData;
        end
    end

    assign ovRdData = mem[ivRdAddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with registered-read or FWFT output, programmable level flags,
// write-while-full on a simultaneous read, and sticky overflow/underflow flags.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int pDepthWidth       = 5,
    parameter int pWordWidth        = 16,
    parameter int pFwft             = 0,
    parameter int pAlmostFullLevel  = 28,
    parameter int pAlmostEmptyLevel = 2
) (
    input  logic                   iClk,
    input  logic                   nReset,
    input  logic                   iWEn,
    input  logic [pWordWidth-1:0]  ivDataIn,
    input  logic                   iREn,
    input  logic                   iClrErr,
    output logic [pWordWidth-1:0]  ovDataOut,
    output logic                   oValid,
    output logic                   qEmpty,
    output logic                   qFull,
    output logic                   qAlmostEmpty,
    output logic                   qAlmostFull,
    output logic [pDepthWidth:0]   qvCount,
    output logic                   qOverflow,
    output logic                   qUnderflow
);

    localparam int cDepth = 2**pDepthWidth;
    localparam logic [pDepthWidth:0]   cDepthCnt = cDepth[pDepthWidth:0];
    localparam logic [pDepthWidth:0]   cAfLevel  = pAlmostFullLevel[pDepthWidth:0];
    localparam logic [pDepthWidth:0]   cAeLevel  = pAlmostEmptyLevel[pDepthWidth:0];
    localparam logic [pDepthWidth:0]   cCntZero  = {(pDepthWidth+1){1'b0}};
    localparam logic [pDepthWidth:0]   cCntOne   = (pDepthWidth+1)'(1'b1);
    localparam logic [pDepthWidth-1:0] cPtrZero  = {pDepthWidth{1'b0}};
    localparam logic [pDepthWidth-1:0] cPtrOne   = pDepthWidth'(1'b1);

    generate
        if ((pAlmostFullLevel < 1) || (pAlmostFullLevel > cDepth) ||
            (pAlmostEmptyLevel < 0) || (pAlmostEmptyLevel >= cDepth) ||
            ((pFwft != FIFO_MODE_REG) && (pFwft != FIFO_MODE_FWFT))) begin : gBadParam
            $error("param_sync_fifo: illegal parameter combination");
        end
    endgenerate

    logic [pDepthWidth-1:0] wrPtr;
    logic [pDepthWidth-1:0] rdPtr;
    logic [pDepthWidth:0]   countNext;
    logic [pWordWidth-1:0]  ramRdData;
    logic                   rdOk;
    logic                   wrOk;

    sync_fifo_ram #(
        .pAddrWidth (pDepthWidth),
        .pWordWidth (pWordWidth)
    ) uRam (
        .iClk     (iClk),
        .iWEn     (wrOk),
        .ivWrAddr (wrPtr),
        .ivWrData (ivDataIn),
        .ivRdAddr (rdPtr),
        .ovRdData (ramRdData)
    );

    // Accept decisions and next-state occupancy; a read frees the slot a full-FIFO write needs
    always_comb begin
        rdOk      = iREn & ~qEmpty;
        wrOk      = iWEn & (~qFull | rdOk);
        countNext = qvCount;
        if (wrOk && !rdOk) begin
            countNext = qvCount + cCntOne;
        end else if (rdOk && !wrOk) begin
            countNext = qvCount - cCntOne;
        end else begin
            countNext = qvCount;
        end
    end

    // Pointers, count, status flags (from next-state count) and sticky errors
    always_ff @(posedge iClk) begin
        if (!nReset) begin
            wrPtr        <= cPtrZero;
            rdPtr        <= cPtrZero;
            qvCount      <= cCntZero;
            qEmpty       <= 1'b1;
            qFull        <= 1'b0;
            qAlmostEmpty <= 1'b1;
            qAlmostFull  <= 1'b0;
            qOverflow    <= 1'b0;
            qUnderflow   <= 1'b0;
        end else begin
            if (wrOk) begin
                wrPtr <= wrPtr + cPtrOne;
            end
            if (rdOk) begin
                rdPtr <= rdPtr + cPtrOne;
            end
            qvCount      <= countNext;
            qEmpty       <= (countNext == cCntZero);
            qFull        <= (countNext == cDepthCnt);
            qAlmostEmpty <= (countNext <= cAeLevel);
            qAlmostFull  <= (countNext >= cAfLevel);
            // A fresh error outranks a simultaneous clear
            if (iWEn && !wrOk) begin
                qOverflow <= 1'b1;
            end else if (iClrErr) begin
                qOverflow <= 1'b0;
            end
            if (iREn && !rdOk) begin
                qUnderflow <= 1'b1;
            end else if (iClrErr) begin
                qUnderflow <= 1'b0;
            end
        end
    end

    generate
        if (pFwft == FIFO_MODE_FWFT) begin : gFwft
            assign ovDataOut = ramRdData;
            assign oValid    = ~qEmpty;
        end else begin : gRegRead
            logic [pWordWidth-1:0] dataReg;
            logic                  validReg;

            // Registered read port; data holds its last value when no word is popped
            always_ff @(posedge iClk) begin
                if (!nReset) begin
                    dataReg  <= {pWordWidth{1'b0}};
                    validReg <= 1'b0;
                end else if (rdOk) begin
                    dataReg  <= ramRdData;
                    validReg <= 1'b1;
                end else begin
                    validReg <= 1'b0;
                end
            end

            assign ovDataOut = dataReg;
            assign oValid    = validReg;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: a registered-read and an FWFT instance share stimulus (D=4, AF=3, AE=1).
module tb_param_sync_fifo;

    logic       iClk = 1'b0;
    logic       nReset = 1'b0;
    logic       iWEn = 1'b0;
    logic [7:0] ivDataIn = 8'h00;
    logic       iREn = 1'b0;
    logic       iClrErr = 1'b0;

    logic [7:0] rData, fData;
    logic       rValid, fValid;
    logic       rEmpty, rFull, rAe, rAf, rOvf, rUdf;
    logic       fEmpty, fFull, fAe, fAf, fOvf, fUdf;
    logic [2:0] rCount, fCount;

    int nVec = 0;
    int nMis = 0;

    always #5 iClk = ~iClk;

    param_sync_fifo #(.pDepthWidth(2), .pWordWidth(8), .pFwft(0),
                      .pAlmostFullLevel(3), .pAlmostEmptyLevel(1)) uReg (
        .iClk(iClk), .nReset(nReset), .iWEn(iWEn), .ivDataIn(ivDataIn),
        .iREn(iREn), .iClrErr(iClrErr), .ovDataOut(rData), .oValid(rValid),
        .qEmpty(rEmpty), .qFull(rFull), .qAlmostEmpty(rAe), .qAlmostFull(rAf),
        .qvCount(rCount), .qOverflow(rOvf), .qUnderflow(rUdf));

    param_sync_fifo #(.pDepthWidth(2), .pWordWidth(8), .pFwft(1),
                      .pAlmostFullLevel(3), .pAlmostEmptyLevel(1)) uFwft (
        .iClk(iClk), .nReset(nReset), .iWEn(iWEn), .ivDataIn(ivDataIn),
        .iREn(iREn), .iClrErr(iClrErr), .ovDataOut(fData), .oValid(fValid),
        .qEmpty(fEmpty), .qFull(fFull), .qAlmostEmpty(fAe), .qAlmostFull(fAf),
        .qvCount(fCount), .qOverflow(fOvf), .qUnderflow(fUdf));

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Status word {count, empty, full, ae, af, ovf, udf} for both instances
    task automatic checkStat(input string tag, input int cnt, input bit ovf, input bit udf);
        logic [8:0] e;
        e = {3'(cnt), (cnt == 0), (cnt == 4), (cnt <= 1), (cnt >= 3), ovf, udf};
        checkVal({tag, " reg stat"},  {23'd0, rCount, rEmpty, rFull, rAe, rAf, rOvf, rUdf}, {23'd0, e});
        checkVal({tag, " fwft stat"}, {23'd0, fCount, fEmpty, fFull, fAe, fAf, fOvf, fUdf}, {23'd0, e});
    endtask

    task automatic cyc(input bit we, input logic [7:0] d, input bit re, input bit clr);
        iWEn = we; ivDataIn = d; iREn = re; iClrErr = clr;
        @(posedge iClk);
        #1;
        iWEn = 1'b0; iREn = 1'b0; iClrErr = 1'b0;
    endtask

    logic [7:0] wrVals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] drainVals [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        nReset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checkStat("reset", 0, 1'b0, 1'b0);
        checkVal("reset reg valid", {31'd0, rValid}, 32'd0);
        checkVal("reset fwft valid", {31'd0, fValid}, 32'd0);
        checkVal("reset reg data", {24'd0, rData}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, wrVals[i], 1'b0, 1'b0);
            checkStat($sformatf("fill%0d", i + 1), i + 1, 1'b0, 1'b0);
            checkVal("fill fwft head", {24'd0, fData}, 32'h11);
            checkVal("fill fwft valid", {31'd0, fValid}, 32'd1);
            checkVal("fill reg valid", {31'd0, rValid}, 32'd0);
        end

        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        checkStat("overflow", 4, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checkStat("clr ovf", 4, 1'b0, 1'b0);

        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        checkStat("full rw", 4, 1'b0, 1'b0);
        checkVal("full rw reg valid", {31'd0, rValid}, 32'd1);
        checkVal("full rw reg data", {24'd0, rData}, 32'h11);

        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("drain%0d fwft data", k), {24'd0, fData}, {24'd0, drainVals[k]});
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            checkVal($sformatf("drain%0d reg data", k), {24'd0, rData}, {24'd0, drainVals[k]});
            checkVal($sformatf("drain%0d reg valid", k), {31'd0, rValid}, 32'd1);
            checkStat($sformatf("drain%0d", k), 3 - k, 1'b0, 1'b0);
        end
        checkVal("drained fwft valid", {31'd0, fValid}, 32'd0);

        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checkStat("underflow", 0, 1'b0, 1'b1);
        checkVal("underflow reg valid", {31'd0, rValid}, 32'd0);
        checkVal("underflow reg data hold", {24'd0, rData}, 32'h55);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checkStat("clr udf", 0, 1'b0, 1'b0);

        // Empty + write + read + clear: write lands, rejected read re-arms underflow
        cyc(1'b1, 8'h66, 1'b1, 1'b1);
        checkStat("empty rw", 1, 1'b0, 1'b1);
        checkVal("empty rw fwft data", {24'd0, fData}, 32'h66);
        checkVal("empty rw reg valid", {31'd0, rValid}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 8'h88, 1'b0, 1'b0);
        checkStat("prefill", 3, 1'b0, 1'b0);

        nReset = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checkStat("mid reset", 0, 1'b0, 1'b0);
        checkVal("mid reset reg valid", {31'd0, rValid}, 32'd0);
        checkVal("mid reset fwft valid", {31'd0, fValid}, 32'd0);
        checkVal("mid reset reg data", {24'd0, rData}, 32'd0);
        nReset = 1'b1;

        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        checkStat("post reset wr", 1, 1'b0, 1'b0);
        checkVal("post reset fwft data", {24'd0, fData}, 32'h99);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("post reset reg data", {24'd0, rData}, 32'h99);
        checkStat("post reset rd", 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
